mod_addsub_serial: RTL

- Limb-serial modular adder/subtractor: computes (x + y) mod P or (x - y) mod P over a WIDTH-bit field.
- Handles both over-range sum (subtract P) and negative difference (add P) correctly.
- Sits in the secp256k1 field-arithmetic layer, feeding point add/double sequencers; trades latency for a LIMB-wide datapath instead of full-width carry chains.
- valid/ready handshake on both sides, one operation in flight.

---
 rtl/mod_addsub_serial.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mod_addsub_serial.sv
// Limb-serial modular adder/subtractor: (x + y) mod P or (x - y) mod P.
// Raw limb pass followed by a correction pass; one operation in flight.
module mod_addsub_serial #(
  parameter int unsigned       WIDTH = 256,
  parameter int unsigned       LIMB  = 64,
  parameter logic [WIDTH-1:0]  P     =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             in_err,
  output logic             busy
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NLIMB - 1);

  typedef enum logic [1:0] {StIdle, StRaw, StCorr, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] x_q, y_q, s_q, t_q, res_q;
  logic             op_q, chain_q, f1_q, err_q;

  logic             last;
  logic [LIMB-1:0]  a_limb, b_limb;
  logic             do_sub;
  logic [LIMB:0]    limb_res;
  logic [WIDTH-1:0] ins_top, s_shift, s_rot, t_next;

  assign last = (cnt_q == LastCnt);

  // Shared LIMB+1 bit adder/subtractor; bit LIMB is the carry/borrow chain bit.
  always_comb begin
    a_limb   = '0;
    b_limb   = '0;
    do_sub   = 1'b0;
    limb_res = '0;
    if (state_q == StRaw) begin
      a_limb = x_q[LIMB-1:0];
      b_limb = y_q[LIMB-1:0];
      do_sub = op_q;
    end else begin
      a_limb = s_q[LIMB-1:0];
      b_limb = P[int'(cnt_q)*LIMB +: LIMB];
      do_sub = ~op_q;
    end
    if (do_sub) begin
      limb_res = {1'b0, a_limb} - {1'b0, b_limb} - {{LIMB{1'b0}}, chain_q};
    end else begin
      limb_res = {1'b0, a_limb} + {1'b0, b_limb} + {{LIMB{1'b0}}, chain_q};
    end
  end

  // New limbs enter at the top so that after NLIMB steps the word is in order.
  always_comb begin
    ins_top = WIDTH'(limb_res[LIMB-1:0]) << (WIDTH - LIMB);
    s_shift = (s_q >> LIMB) | ins_top;
    t_next  = (t_q >> LIMB) | ins_top;
    // The correction pass rotates s so it is intact again after the last limb.
    s_rot   = (s_q >> LIMB) | (s_q << (WIDTH - LIMB));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRaw;
      StRaw:   if (last) state_d = StCorr;
      StCorr:  if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    result    = res_q;
    in_err    = err_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      chain_q <= 1'b0;
      f1_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q     <= x;
            y_q     <= y;
            op_q    <= op;
            err_q   <= (x >= P) || (y >= P);
            chain_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StRaw: begin
          x_q <= x_q >> LIMB;
          y_q <= y_q >> LIMB;
          s_q <= s_shift;
          if (last) begin
            f1_q    <= limb_res[LIMB];
            chain_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            chain_q <= limb_res[LIMB];
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        StCorr: begin
          s_q <= s_rot;
          t_q <= t_next;
          if (last) begin
            chain_q <= 1'b0;
            cnt_q   <= '0;
            // add: t if the sum overflowed or s >= P; sub: t if x - y went negative
            if (op_q) begin
              res_q <= f1_q ? t_next : s_rot;
            end else begin
              res_q <= (f1_q || !limb_res[LIMB]) ? t_next : s_rot;
            end
          end else begin
            chain_q <= limb_res[LIMB];
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

endmodule
